// File: rtl/escalonador_maquinas_if.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_maquinas_if
// Description : Machine request / resource grant bundle for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface escalonador_maquinas_if;
  logic       m1;
  logic       m2;
  logic       m3;
  logic       m4;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic       ocupado;
  logic [1:0] ativo;
  logic       expirou;

  // Machine side drives requests and observes grants.
  modport master (
    output m1, m2, m3, m4,
    input  c1, c2, c3, c4, ocupado, ativo, expirou
  );

  modport slave (
    input  m1, m2, m3, m4,
    output c1, c2, c3, c4, ocupado, ativo, expirou
  );
endinterface : escalonador_maquinas_if
`default_nettype wire

// File: rtl/escalonador_maquinas.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_maquinas
// Description : Round-robin, time-sliced arbiter sharing one resource among
//               four machines, with break-before-make gap between grants.
// Revision    : 1.0 - initial release
// ============================================================================
module escalonador_maquinas #(
  parameter int HOLD_MAX = 8,
  parameter int GAP      = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  escalonador_maquinas_if.slave bus
);

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    CONCEDIDO = 2'd1,
    INTERVALO = 2'd2
  } state_t;

  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [3:0] c_GAP_LAST  = 4'(GAP - 1);

  state_t     r_state;
  logic [3:0] r_grant;
  logic [1:0] r_ativo;
  logic [7:0] r_hold;
  logic [3:0] r_gap;
  logic       r_expirou;
  logic       r_ocupado;

  state_t     w_state_nx;
  logic [3:0] w_grant_nx;
  logic [1:0] w_ativo_nx;
  logic [7:0] w_hold_nx;
  logic [3:0] w_gap_nx;
  logic       w_expirou_nx;
  logic       w_ocupado_nx;

  logic [3:0] w_req;
  logic [2:0] w_arb;
  logic       w_win_valid;
  logic [1:0] w_win_idx;
  logic [3:0] w_win_onehot;

  // Scans from last+4 down to last+1 so the final hit is the one closest
  // after the last served index; last itself is checked with lowest priority.
  function automatic logic [2:0] f_arbitrate(input logic [3:0] req,
                                              input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  assign w_req        = {bus.m4, bus.m3, bus.m2, bus.m1};
  assign w_arb        = f_arbitrate(w_req, r_ativo);
  assign w_win_valid  = w_arb[2];
  assign w_win_idx    = w_arb[1:0];
  assign w_win_onehot = 4'b0001 << w_win_idx;

  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_ativo_nx   = r_ativo;
    w_hold_nx    = r_hold;
    w_gap_nx     = r_gap;
    w_expirou_nx = 1'b0;

    case (r_state)
      LIVRE: begin
        w_grant_nx = 4'b0000;
        if (w_win_valid) begin
          w_grant_nx = w_win_onehot;
          w_ativo_nx = w_win_idx;
          w_hold_nx  = 8'd0;
          w_state_nx = CONCEDIDO;
        end
      end

      CONCEDIDO: begin
        // A dropped request takes precedence over timeout for classification.
        if (!w_req[r_ativo]) begin
          w_grant_nx = 4'b0000;
          w_gap_nx   = 4'd0;
          w_state_nx = INTERVALO;
        end else if (r_hold == c_HOLD_LAST) begin
          w_grant_nx   = 4'b0000;
          w_gap_nx     = 4'd0;
          w_expirou_nx = 1'b1;
          w_state_nx   = INTERVALO;
        end else begin
          w_hold_nx = r_hold + 8'd1;
        end
      end

      INTERVALO: begin
        w_grant_nx = 4'b0000;
        if (r_gap == c_GAP_LAST) begin
          if (w_win_valid) begin
            w_grant_nx = w_win_onehot;
            w_ativo_nx = w_win_idx;
            w_hold_nx  = 8'd0;
            w_state_nx = CONCEDIDO;
          end else begin
            w_state_nx = LIVRE;
          end
        end else begin
          w_gap_nx = r_gap + 4'd1;
        end
      end

      default: begin
        w_grant_nx = 4'b0000;
        w_state_nx = LIVRE;
      end
    endcase

    w_ocupado_nx = |w_grant_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LIVRE;
      r_grant   <= 4'b0000;
      r_ativo   <= 2'd3;
      r_hold    <= 8'd0;
      r_gap     <= 4'd0;
      r_expirou <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_ativo   <= w_ativo_nx;
      r_hold    <= w_hold_nx;
      r_gap     <= w_gap_nx;
      r_expirou <= w_expirou_nx;
      r_ocupado <= w_ocupado_nx;
    end
  end

  assign bus.c1      = r_grant[0];
  assign bus.c2      = r_grant[1];
  assign bus.c3      = r_grant[2];
  assign bus.c4      = r_grant[3];
  assign bus.ocupado = r_ocupado;
  assign bus.ativo   = r_ativo;
  assign bus.expirou = r_expirou;

endmodule : escalonador_maquinas
`default_nettype wire

// File: tb/tb_escalonador_maquinas.sv
`default_nettype none
// ============================================================================
// Module      : tb_escalonador_maquinas
// Description : Scoreboard bench for the round-robin machine scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escalonador_maquinas;

  logic clk;
  logic rst;

  escalonador_maquinas_if u_if ();

  escalonador_maquinas #(
    .HOLD_MAX (8),
    .GAP      (1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Observation word: {c4,c3,c2,c1, ocupado, ativo[1:0], expirou}
  logic [7:0] w_obs;
  assign w_obs = {u_if.c4, u_if.c3, u_if.c2, u_if.c1,
                  u_if.ocupado, u_if.ativo, u_if.expirou};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got c=%b ocupado=%b ativo=%0d expirou=%b, expected c=%b ocupado=%b ativo=%0d expirou=%b",
               name, $time, act[7:4], act[3], act[2:1], act[0],
               exp[7:4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  // Drive requests for n cycles; after each edge the given outputs are due.
  task automatic run(input string name, input logic [3:0] m, input logic [3:0] c,
                     input logic [1:0] a, input logic e, input int n);
    exp_t item;
    for (int i = 0; i < n; i++) begin
      {u_if.m4, u_if.m3, u_if.m2, u_if.m1} = m;
      @(posedge clk);
      item.name = name;
      item.exp  = {c, |c, a, e};
      q_exp.push_back(item);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t item;
    n_checks++;
    if ($countones({u_if.c4, u_if.c3, u_if.c2, u_if.c1}) > 1) begin
      n_fail++;
      $display("FAIL onehot @%0t: got c=%b, expected at most one grant high",
               $time, {u_if.c4, u_if.c3, u_if.c2, u_if.c1});
    end
    if (q_exp.size() > 0) begin
      item = q_exp.pop_front();
      check(item.name, w_obs, item.exp);
    end
  end

  initial begin
    rst = 1'b1;
    {u_if.m4, u_if.m3, u_if.m2, u_if.m1} = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", w_obs, 8'b0000_0_11_0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Full contention from reset: m1 first, then strict rotation.
    run("cont_c1",   4'b1111, 4'b0001, 2'd0, 1'b0, 8);
    run("cont_gap1", 4'b1111, 4'b0000, 2'd0, 1'b1, 1);
    run("cont_c2",   4'b1111, 4'b0010, 2'd1, 1'b0, 8);
    run("cont_gap2", 4'b1111, 4'b0000, 2'd1, 1'b1, 1);
    run("cont_c3",   4'b1111, 4'b0100, 2'd2, 1'b0, 8);
    run("cont_gap3", 4'b1111, 4'b0000, 2'd2, 1'b1, 1);
    run("cont_c4",   4'b1111, 4'b1000, 2'd3, 1'b0, 8);
    run("cont_gap4", 4'b1111, 4'b0000, 2'd3, 1'b1, 1);
    run("cont_c1b",  4'b1111, 4'b0001, 2'd0, 1'b0, 8);
    run("cont_drop", 4'b0000, 4'b0000, 2'd0, 1'b0, 2);

    // Sole requester m2 re-wins after its own timeout.
    run("solo_c2",   4'b0010, 4'b0010, 2'd1, 1'b0, 8);
    run("solo_gap",  4'b0010, 4'b0000, 2'd1, 1'b1, 1);
    run("solo_c2b",  4'b0010, 4'b0010, 2'd1, 1'b0, 8);
    run("solo_drop", 4'b0000, 4'b0000, 2'd1, 1'b0, 3);

    // Early release of m3, then re-grant, then drop on its 8th cycle.
    run("early_c3",  4'b0100, 4'b0100, 2'd2, 1'b0, 3);
    run("early_rel", 4'b0000, 4'b0000, 2'd2, 1'b0, 2);
    run("regrant",   4'b0100, 4'b0100, 2'd2, 1'b0, 8);
    run("simul_rel", 4'b0000, 4'b0000, 2'd2, 1'b0, 2);

    // Leave ativo = 1, then m1 and m3 contend: m3 first, then m1.
    run("pre_c2",    4'b0010, 4'b0010, 2'd1, 1'b0, 2);
    run("pre_idle",  4'b0000, 4'b0000, 2'd1, 1'b0, 2);
    run("rr_c3",     4'b0101, 4'b0100, 2'd2, 1'b0, 8);
    run("rr_gap",    4'b0101, 4'b0000, 2'd2, 1'b1, 1);
    run("rr_c1",     4'b0101, 4'b0001, 2'd0, 1'b0, 8);
    run("rr_gap2",   4'b0101, 4'b0000, 2'd0, 1'b1, 1);
    run("pre_c4",    4'b1000, 4'b1000, 2'd3, 1'b0, 3);

    // Asynchronous reset while c4 is granted.
    @(negedge clk);
    #1;
    check("pre_async_c4", w_obs, 8'b1000_1_11_0);
    {u_if.m4, u_if.m3, u_if.m2, u_if.m1} = 4'b1001;
    rst = 1'b1;
    #1;
    check("async_rst", w_obs, 8'b0000_0_11_0);
    @(posedge clk);
    #1;
    check("rst_held", w_obs, 8'b0000_0_11_0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    run("post_rst_c1", 4'b1001, 4'b0001, 2'd0, 1'b0, 1);
    run("post_rst_rel", 4'b0000, 4'b0000, 2'd0, 1'b0, 2);

    for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(negedge clk);
    #1;
    if (q_exp.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_escalonador_maquinas
`default_nettype wire
